floo_meta_remap_table: RTL and testbench
========================================

Name: floo_meta_remap_table

Overview:
- Generalised per-transaction meta buffer for one request/response channel pair; instantiated once for AR/R and once for AW/B.
- Every accepted request gets a unique slot, and so a unique downstream ID, from a free pool. Its meta word is stored in that slot.
- The matching response looks up the meta word by returned ID. The slot is released on the last response beat.
- Adds a usage counter, stray-response detection and optional per-slot timeout.

Parameters:
- NumSlots, 8, maximum outstanding transactions (>=2).
- MetaWidth, 32, bits of meta stored per transaction.
- OutIdWidth, 3, downstream ID width; must satisfy 2**OutIdWidth >= NumSlots (elaboration assertion).
- TimeoutCycles, 1024, cycles a slot may stay busy before timeout is flagged (used only with the optional feature).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_valid_i  in  1  upstream request valid
- req_ready_o  out  1  upstream request ready
- req_meta_i  in  MetaWidth  meta word to store
- req_valid_o  out  1  downstream request valid
- req_ready_i  in  1  downstream request ready
- req_id_o  out  OutIdWidth  allocated slot index used as downstream ID
- rsp_valid_i  in  1  downstream response valid
- rsp_ready_o  out  1  downstream response ready
- rsp_id_i  in  OutIdWidth  response ID
- rsp_last_i  in  1  last beat of response
- rsp_valid_o  out  1  upstream response valid
- rsp_ready_i  in  1  upstream response ready
- rsp_meta_o  out  MetaWidth  meta of the responding slot
- rsp_stray_o  out  1  response ID not busy
- usage_o  out  $clog2(NumSlots+1)  busy slot count
- full_o  out  1  no free slot
- timeout_o  out  NumSlots  per-slot timeout flags

Behaviour:
- State:
  - busy_q[NumSlots], reset 0.
  - meta_q[NumSlots], reset 0.
  - lock_q (1b) and lock_id_q, both reset 0.
  - usage_q, reset 0.
- Reset values while rst_i is asserted:
  - req_ready_o=0 and req_valid_o=0.
  - full_o=0, usage_o=0, timeout_o=0.
  - rsp_meta_o=0 and rsp_stray_o=rsp_valid_i.
- Reset mid-operation frees all slots. Outstanding responses that arrive afterwards are strays.
- Allocation:
  - cand = lowest-index slot with busy_q=0.
  - any_free = |~busy_q.
  - full_o = ~any_free.
- Request path (zero latency, combinational):
  - req_valid_o = req_valid_i & any_free.
  - req_ready_o = req_ready_i & any_free.
  - req_id_o = lock_q ? lock_id_q : cand.
- ID stability under the valid-hold rule:
  - If req_valid_o=1 and req_ready_i=0, the next cycle has lock_q=1 and lock_id_q=req_id_o.
  - lock_q clears on handshake.
  - While locked, the locked slot is still free, so any_free=1 and the request cannot drop.
- Accept (req_valid_o & req_ready_i): busy_q[req_id_o]<=1 and meta_q[req_id_o]<=req_meta_i, visible next cycle.
- Response path (pass-through):
  - rsp_valid_o = rsp_valid_i.
  - rsp_ready_o = rsp_ready_i.
  - rsp_meta_o = busy_q[rsp_id_i] ? meta_q[rsp_id_i] : 0.
  - rsp_stray_o = rsp_valid_i & (~busy_q[rsp_id_i] | rsp_id_i>=NumSlots).
  - A stray response changes no state.
- Release: rsp_valid_i & rsp_ready_i & rsp_last_i & ~stray sets busy_q[rsp_id_i]<=0. Non-last beats leave the slot busy.
- Simultaneous allocate and release:
  - Allocation uses the pre-release busy_q, so a released slot is reusable from the next cycle (no bypass).
  - usage_q is unchanged when both occur, +1 on accept only, -1 on release only.
- Full boundary:
  - usage_q=NumSlots implies full_o=1 and req_ready_o=0.
  - A release in that cycle clears full_o the next cycle.
- usage_o = usage_q (registered). Invariant asserted: usage_q == popcount(busy_q).

Optional Feature:
- Macro: FLOO_META_TIMEOUT_EN.
- Defined:
  - Each slot has age counter age_q of width $clog2(TimeoutCycles+1), reset 0.
  - The counter is cleared on accept and increments each cycle while busy, saturating at TimeoutCycles.
  - timeout_o[i] = busy_q[i] & (age_q[i]==TimeoutCycles).
  - The flag clears the cycle after release.
  - Timeout is informational only; the slot stays busy.
- Undefined: timeout_o tied 0; no counters synthesised.

Decomposition:
- Package floo_meta_pkg holds:
  - the slot-count width function, slot_idx_t sizing helper and usage_t sizing helper;
  - the OutIdWidth >= $clog2(NumSlots) check constant.
- meta_t is passed as a parameter.
- One sub-module: floo_meta_slot_alloc, containing the priority encoder, lock_q/lock_id_q and any_free/cand generation.

Test Plan:
- Reset, then three requests with meta 0xA,0xB,0xC and req_ready_i=1 -> req_id_o 0,1,2; usage_o=3; responses ID1, ID0, ID2 with last=1 -> rsp_meta_o 0xB, 0xA, 0xC; usage_o=0.
- Fill all 8 slots -> full_o=1 and req_ready_o=0. Release ID5 and hold a request in the same cycle -> not accepted that cycle; next cycle accepted with req_id_o=5.
- req_valid_i held, req_ready_i=0 for 4 cycles while slot 0 releases mid-wait -> req_id_o stays at its first value; on accept that slot becomes busy.
- 4-beat response on ID2 (last on beat 4) -> slot 2 busy through beat 3; usage_o decrements only after beat 4; repeat with rsp_ready_i toggling.
- Response with ID6 when slot 6 is free -> rsp_stray_o=1, rsp_meta_o=0, state unchanged. Assert rst_i with 5 busy slots -> usage_o=0 and full_o=0 the next cycle.
- FLOO_META_TIMEOUT_EN with TimeoutCycles=16: leave ID3 outstanding -> timeout_o[3]=1 from 16 cycles after accept; release -> 0 the next cycle. Without the macro -> timeout_o=0 throughout.

Source files
------------

// File: rtl/floo_meta_pkg.sv
// floo_meta_pkg
// Sizing helpers shared by the meta remap table and its slot allocator.
//   cnt_width      : bits needed to hold a count in 0..n
//   slot_idx_width : bits needed to index n slots (at least 1)
//   usage_width    : width of the busy-slot counter for n slots
//   id_width_ok    : true when a downstream ID of width w can name every slot
package floo_meta_pkg;

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  function automatic int unsigned slot_idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned usage_width(input int unsigned n);
    return cnt_width(n);
  endfunction

  function automatic bit id_width_ok(input int unsigned n, input int unsigned w);
    return (w >= slot_idx_width(n)) && ((64'd1 << w) >= 64'(n));
  endfunction

endpackage

// File: rtl/floo_meta_slot_alloc.sv
// floo_meta_slot_alloc
// Picks the downstream ID for the next request: the lowest free slot, frozen
// while a presented request waits for req_ready_i so the ID cannot change
// under a held valid.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   busy_i         per-slot busy flags
//   req_valid_i    upstream request valid
//   req_ready_i    downstream request ready
//   any_free_o     at least one slot is free
//   id_o           ID to present downstream
module floo_meta_slot_alloc
  import floo_meta_pkg::*;
#(
  parameter int unsigned NumSlots   = 8,
  parameter int unsigned OutIdWidth = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NumSlots-1:0]   busy_i,
  input  logic                  req_valid_i,
  input  logic                  req_ready_i,
  output logic                  any_free_o,
  output logic [OutIdWidth-1:0] id_o
);

  logic                  lock_q;
  logic [OutIdWidth-1:0] lock_id_q;
  logic [OutIdWidth-1:0] cand;
  logic                  stall;

  // Scan downwards so the last hit is the lowest free index.
  always_comb begin
    cand = '0;
    for (int i = NumSlots - 1; i >= 0; i--) begin
      if (!busy_i[i]) cand = OutIdWidth'(i);
    end
  end

  assign any_free_o = ~&busy_i;
  assign id_o       = lock_q ? lock_id_q : cand;
  assign stall      = req_valid_i & any_free_o & ~req_ready_i;

  // The locked slot stays free until its own accept, so any_free_o cannot
  // drop while locked.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_q    <= 1'b0;
      lock_id_q <= '0;
    end else begin
      lock_q <= stall;
      if (stall) lock_id_q <= id_o;
    end
  end

endmodule

// File: rtl/floo_meta_remap_table.sv
// floo_meta_remap_table
// Per-transaction meta buffer for one request/response channel pair. Each
// accepted request takes a free slot whose index becomes its downstream ID;
// the response looks its meta back up by ID and frees the slot on its last
// beat. Build with FLOO_META_TIMEOUT_EN for per-slot age tracking.
// Ports:
//   clk_i, rst_i                         clock, synchronous active-high reset
//   req_valid_i/req_ready_o/req_meta_i   upstream request
//   req_valid_o/req_ready_i/req_id_o     downstream request with slot ID
//   rsp_valid_i/rsp_ready_o/rsp_id_i/rsp_last_i   downstream response
//   rsp_valid_o/rsp_ready_i/rsp_meta_o/rsp_stray_o upstream response + meta
//   usage_o, full_o                      busy slot count, no free slot
//   timeout_o                            per-slot timeout flags
module floo_meta_remap_table
  import floo_meta_pkg::*;
#(
  parameter int unsigned NumSlots      = 8,
  parameter int unsigned MetaWidth     = 32,
  parameter int unsigned OutIdWidth    = 3,
  parameter int unsigned TimeoutCycles = 1024,
  parameter type         meta_t        = logic [MetaWidth-1:0]
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic [MetaWidth-1:0]           req_meta_i,
  output logic                           req_valid_o,
  input  logic                           req_ready_i,
  output logic [OutIdWidth-1:0]          req_id_o,
  input  logic                           rsp_valid_i,
  output logic                           rsp_ready_o,
  input  logic [OutIdWidth-1:0]          rsp_id_i,
  input  logic                           rsp_last_i,
  output logic                           rsp_valid_o,
  input  logic                           rsp_ready_i,
  output logic [MetaWidth-1:0]           rsp_meta_o,
  output logic                           rsp_stray_o,
  output logic [$clog2(NumSlots+1)-1:0]  usage_o,
  output logic                           full_o,
  output logic [NumSlots-1:0]            timeout_o
);

  localparam int unsigned IdxW    = slot_idx_width(NumSlots);
  localparam int unsigned UsageW  = usage_width(NumSlots);
  localparam int unsigned IdSpace = 1 << OutIdWidth;

  typedef logic [IdxW-1:0]   slot_idx_t;
  typedef logic [UsageW-1:0] usage_t;

  if (NumSlots < 2) begin : g_chk_slots
    $error("NumSlots must be at least 2");
  end
  if (!id_width_ok(NumSlots, OutIdWidth)) begin : g_chk_id
    $error("OutIdWidth too narrow for NumSlots");
  end
  if ($bits(meta_t) != MetaWidth) begin : g_chk_meta
    $error("meta_t width must equal MetaWidth");
  end
  if (TimeoutCycles < 1) begin : g_chk_tmo
    $error("TimeoutCycles must be at least 1");
  end

  logic [NumSlots-1:0]   busy_q;
  meta_t                 meta_q [NumSlots];
  usage_t                usage_q;
  logic                  any_free;
  logic [OutIdWidth-1:0] alloc_id;
  logic                  accept;
  logic                  release_en;
  logic                  stray;
  slot_idx_t             req_slot;
  slot_idx_t             rsp_slot;
  logic [IdSpace-1:0]    busy_ext;
  logic [MetaWidth-1:0]  meta_sel;

  floo_meta_slot_alloc #(
    .NumSlots   (NumSlots),
    .OutIdWidth (OutIdWidth)
  ) u_alloc (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .busy_i      (busy_q),
    .req_valid_i (req_valid_i),
    .req_ready_i (req_ready_i),
    .any_free_o  (any_free),
    .id_o        (alloc_id)
  );

  assign req_valid_o = req_valid_i & any_free & ~rst_i;
  assign req_ready_o = req_ready_i & any_free & ~rst_i;
  assign req_id_o    = alloc_id;
  assign full_o      = ~any_free & ~rst_i;
  assign usage_o     = rst_i ? '0 : usage_q;

  assign accept   = req_valid_o & req_ready_i;
  assign req_slot = alloc_id[IdxW-1:0];

  // IDs beyond NumSlots land on the zero padding and therefore read as free.
  assign busy_ext   = IdSpace'(busy_q);
  assign rsp_slot   = rsp_id_i[IdxW-1:0];
  assign stray      = rsp_valid_i & ~busy_ext[rsp_id_i];
  assign release_en = rsp_valid_i & rsp_ready_i & rsp_last_i & ~stray;
  assign meta_sel   = meta_q[rsp_slot];

  assign rsp_valid_o = rsp_valid_i;
  assign rsp_ready_o = rsp_ready_i;
  assign rsp_meta_o  = (~rst_i & busy_ext[rsp_id_i]) ? meta_sel : '0;
  assign rsp_stray_o = rst_i ? rsp_valid_i : stray;

  // Accept targets a free slot and release a busy one, so the two writes
  // never collide; the freed slot is only reusable next cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q  <= '0;
      usage_q <= '0;
      for (int i = 0; i < NumSlots; i++) meta_q[i] <= '0;
    end else begin
      if (release_en) busy_q[rsp_slot] <= 1'b0;
      if (accept) begin
        busy_q[req_slot] <= 1'b1;
        meta_q[req_slot] <= meta_t'(req_meta_i);
      end
      case ({accept, release_en})
        2'b10:   usage_q <= usage_q + usage_t'(1);
        2'b01:   usage_q <= usage_q - usage_t'(1);
        default: usage_q <= usage_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) assert (usage_q == usage_t'($countones(busy_q)));
  end

`ifdef FLOO_META_TIMEOUT_EN
  localparam int unsigned AgeW = cnt_width(TimeoutCycles);
  typedef logic [AgeW-1:0] age_t;

  age_t                age_q [NumSlots];
  logic [NumSlots-1:0] timeout_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumSlots; i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < NumSlots; i++) begin
        if (accept && (req_slot == slot_idx_t'(i))) begin
          age_q[i] <= '0;
        end else if (busy_q[i] && (age_q[i] != age_t'(TimeoutCycles))) begin
          age_q[i] <= age_q[i] + age_t'(1);
        end
      end
    end
  end

  always_comb begin
    timeout_d = '0;
    for (int i = 0; i < NumSlots; i++) begin
      timeout_d[i] = busy_q[i] & (age_q[i] == age_t'(TimeoutCycles));
    end
  end

  assign timeout_o = rst_i ? '0 : timeout_d;
`else
  assign timeout_o = '0;
`endif

endmodule

// File: tb/tb_floo_meta_remap_table.sv
module tb_floo_meta_remap_table;

  localparam int N  = 8;
  localparam int MW = 32;
  localparam int IW = 3;
  localparam int TC = 16;
`ifdef FLOO_META_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk;
  logic          rst_i;
  logic          req_valid_i, req_ready_o, req_valid_o, req_ready_i;
  logic [MW-1:0] req_meta_i;
  logic [IW-1:0] req_id_o;
  logic          rsp_valid_i, rsp_ready_o, rsp_last_i, rsp_valid_o, rsp_ready_i;
  logic [IW-1:0] rsp_id_i;
  logic [MW-1:0] rsp_meta_o;
  logic          rsp_stray_o;
  logic [3:0]    usage_o;
  logic          full_o;
  logic [N-1:0]  timeout_o;

  floo_meta_remap_table #(
    .NumSlots(N), .MetaWidth(MW), .OutIdWidth(IW), .TimeoutCycles(TC)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_meta_i(req_meta_i),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_id_o(req_id_o),
    .rsp_valid_i(rsp_valid_i), .rsp_ready_o(rsp_ready_o), .rsp_id_i(rsp_id_i),
    .rsp_last_i(rsp_last_i), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_meta_o(rsp_meta_o), .rsp_stray_o(rsp_stray_o),
    .usage_o(usage_o), .full_o(full_o), .timeout_o(timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int usage; bit full; logic [N-1:0] tmo; } st_e;
  typedef struct { int id; bit rdy; } rq_e;
  typedef struct { logic [MW-1:0] meta; bit stray; bit rdy; } rs_e;

  st_e st_q[$];
  rq_e rq_q[$];
  rs_e rs_q[$];

  // Reference model: a pool of slots with their meta, a count and ages.
  bit            busy_m [N];
  logic [MW-1:0] meta_m [N];
  int            age_m  [N];
  int            usage_m;
  bit            lock_m;
  int            lock_id_m;

  int tests = 0;
  int fails = 0;
  bit running = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest_free();
    for (int i = 0; i < N; i++) if (!busy_m[i]) return i;
    return -1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      busy_m[i] = 0; meta_m[i] = '0; age_m[i] = 0;
    end
    usage_m = 0; lock_m = 0; lock_id_m = 0;
  endtask

  // One clock of stimulus; called at posedge+1. Expectations describe what the
  // DUT must show during this cycle, then the model advances past the edge.
  task automatic cycle(input bit rv, input bit rr, input logic [MW-1:0] meta,
                       input bit sv, input int sid, input bit sl, input bit sr);
    st_e s; rq_e q; rs_e r;
    bit free, acc, rel, str;
    int id;
    free = (usage_m < N);
    id   = lock_m ? lock_id_m : lowest_free();
    s.usage = usage_m; s.full = !free; s.tmo = '0;
    for (int i = 0; i < N; i++) s.tmo[i] = TO_EN && busy_m[i] && (age_m[i] == TC);
    st_q.push_back(s);
    acc = rv && rr && free;
    if (rv && free) begin q.id = id; q.rdy = rr; rq_q.push_back(q); end
    str = !busy_m[sid];
    if (sv) begin
      r.meta = str ? '0 : meta_m[sid]; r.stray = str; r.rdy = sr;
      rs_q.push_back(r);
    end
    rel = sv && sr && sl && !str;
    for (int i = 0; i < N; i++) begin
      if (acc && i == id) age_m[i] = 0;
      else if (busy_m[i] && age_m[i] < TC) age_m[i]++;
    end
    if (acc) begin busy_m[id] = 1; meta_m[id] = meta; usage_m++; end
    if (rel) begin busy_m[sid] = 0; usage_m--; end
    lock_m = rv && free && !rr;
    if (lock_m) lock_id_m = id;
    req_valid_i = rv; req_ready_i = rr; req_meta_i = meta;
    rsp_valid_i = sv; rsp_id_i = IW'(sid); rsp_last_i = sl; rsp_ready_i = sr;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    cycle(0, 0, '0, 0, 0, 0, 1);
  endtask

  task automatic do_reset(input bit sv, input int sid);
    rst_i = 1; req_valid_i = 1; req_ready_i = 1; req_meta_i = '1;
    rsp_valid_i = sv; rsp_id_i = IW'(sid); rsp_last_i = 1; rsp_ready_i = 1;
    @(negedge clk);
    chk("rst_req_valid", req_valid_o, 0);
    chk("rst_req_ready", req_ready_o, 0);
    chk("rst_full", full_o, 0);
    chk("rst_usage", usage_o, 0);
    chk("rst_timeout", timeout_o, 0);
    chk("rst_rsp_meta", rsp_meta_o, 0);
    chk("rst_rsp_stray", rsp_stray_o, sv);
    @(posedge clk); #1;
    rst_i = 0; req_valid_i = 0; req_ready_i = 0; rsp_valid_i = 0; rsp_last_i = 0;
    model_clear();
    st_q.delete(); rq_q.delete(); rs_q.delete();
  endtask

  st_e ms; rq_e mq; rs_e mr;

  always @(negedge clk) begin
    if (running && !rst_i) begin
      if (st_q.size() != 0) begin
        ms = st_q.pop_front();
        chk("usage", usage_o, ms.usage);
        chk("full", full_o, ms.full);
        chk("timeout", timeout_o, ms.tmo);
      end
      if (req_valid_o) begin
        if (rq_q.size() == 0) chk("req_valid_unexpected", req_valid_o, 0);
        else begin
          mq = rq_q.pop_front();
          chk("req_id", req_id_o, mq.id);
          chk("req_ready", req_ready_o, mq.rdy);
        end
      end else if (rq_q.size() != 0) begin
        chk("req_valid_missing", req_valid_o, 1);
        rq_q.delete();
      end
      if (rsp_valid_o) begin
        if (rs_q.size() == 0) chk("rsp_valid_unexpected", rsp_valid_o, 0);
        else begin
          mr = rs_q.pop_front();
          chk("rsp_meta", rsp_meta_o, mr.meta);
          chk("rsp_stray", rsp_stray_o, mr.stray);
          chk("rsp_ready", rsp_ready_o, mr.rdy);
        end
      end else if (rs_q.size() != 0) begin
        chk("rsp_valid_missing", rsp_valid_o, 1);
        rs_q.delete();
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit hold;
    bit rv, rr;
    logic [MW-1:0] hmeta, m;
    rst_i = 1; req_valid_i = 0; req_ready_i = 0; req_meta_i = '0;
    rsp_valid_i = 0; rsp_id_i = '0; rsp_last_i = 0; rsp_ready_i = 0;
    model_clear();
    @(posedge clk); #1;
    running = 1;
    do_reset(0, 0);

    // basic allocate / out-of-order lookup
    cycle(1, 1, 32'hA, 0, 0, 0, 1);
    cycle(1, 1, 32'hB, 0, 0, 0, 1);
    cycle(1, 1, 32'hC, 0, 0, 0, 1);
    idle();
    cycle(0, 0, '0, 1, 1, 1, 1);
    cycle(0, 0, '0, 1, 0, 1, 1);
    cycle(0, 0, '0, 1, 2, 1, 1);
    idle();

    // full boundary with same-cycle release
    repeat (N) cycle(1, 1, $urandom, 0, 0, 0, 1);
    m = $urandom;
    cycle(1, 1, m, 1, 5, 1, 1);
    cycle(1, 1, m, 0, 0, 0, 1);
    idle();

    // held valid with a lower slot freed mid-wait
    cycle(0, 0, '0, 1, 3, 1, 1);
    m = $urandom;
    cycle(1, 0, m, 0, 0, 0, 1);
    cycle(1, 0, m, 1, 0, 1, 1);
    cycle(1, 0, m, 0, 0, 0, 1);
    cycle(1, 0, m, 0, 0, 0, 1);
    cycle(1, 1, m, 0, 0, 0, 1);
    cycle(1, 1, $urandom, 0, 0, 0, 1);
    idle();

    // multi-beat responses on slot 2
    repeat (3) cycle(0, 0, '0, 1, 2, 0, 1);
    cycle(0, 0, '0, 1, 2, 1, 1);
    idle();
    cycle(1, 1, $urandom, 0, 0, 0, 1);
    cycle(0, 0, '0, 1, 2, 0, 1);
    cycle(0, 0, '0, 1, 2, 0, 0);
    cycle(0, 0, '0, 1, 2, 0, 1);
    cycle(0, 0, '0, 1, 2, 1, 0);
    cycle(0, 0, '0, 1, 2, 1, 1);
    idle();

    // stray responses
    cycle(0, 0, '0, 1, 6, 1, 1);
    cycle(0, 0, '0, 1, 6, 1, 1);
    cycle(0, 0, '0, 1, 6, 0, 1);
    idle();

    // reset with 5 busy slots
    do_reset(0, 0);
    repeat (5) cycle(1, 1, $urandom, 0, 0, 0, 1);
    idle();
    do_reset(1, 1);
    idle();
    cycle(0, 0, '0, 1, 1, 1, 1);
    idle();

    // long-outstanding slot 3
    repeat (4) cycle(1, 1, $urandom, 0, 0, 0, 1);
    cycle(0, 0, '0, 1, 0, 1, 1);
    cycle(0, 0, '0, 1, 1, 1, 1);
    cycle(0, 0, '0, 1, 2, 1, 1);
    repeat (20) idle();
    cycle(0, 0, '0, 1, 3, 1, 1);
    repeat (2) idle();

    // randomized traffic
    hold = 0; hmeta = '0;
    for (int c = 0; c < 600; c++) begin
      if (c == 300) begin do_reset(1, $urandom_range(0, N - 1)); hold = 0; end
      rv = hold ? 1'b1 : ($urandom_range(0, 2) != 0);
      m  = hold ? hmeta : $urandom;
      rr = ($urandom_range(0, 3) != 0);
      hold  = rv && !(rr && (usage_m < N));
      hmeta = m;
      cycle(rv, rr, m, $urandom_range(0, 1) != 0, $urandom_range(0, N - 1),
            $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0);
    end
    idle();
    @(negedge clk);
    running = 0;
    chk("queues_drained", st_q.size() + rq_q.size() + rs_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
